// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8-bit UART receiver feeding a synchronous byte FIFO.
// Optional even parity is enabled with `define UART_RX_PARITY_EN.
// Ports:
//   clk_50m    system clock (rising edge)
//   reset      synchronous active-high reset
//   rx         asynchronous serial input (idle high)
//   rd_en      pop one byte when not empty
//   data_out   registered read data
//   used_words FIFO occupancy
//   empty/full occupancy flags
//   rx_busy    receiver not idle
//   frame_err  one-cycle pulse on bad stop (or parity)
//   overrun    sticky: byte dropped on a full FIFO
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk_50m,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     rd_en,
  output logic [7:0]               data_out,
  output logic [$clog2(DEPTH):0]   used_words,
  output logic                     empty,
  output logic                     full,
  output logic                     rx_busy,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned LAST_BIT = 8;
`else
  localparam int unsigned LAST_BIT = 7;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t             state, state_next;
  logic               rx_m, rx_s, rx_s_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         tick_cnt;
  logic [3:0]         bit_cnt;
  logic [7:0]         shift;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               tick_c, sample_c, fall_c;
  logic               start_c, shift_c, push_c, err_c, bad_par_c;
  logic               do_wr_c, do_rd_c;
  logic [CNT_W-1:0]   used_next_c;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  assign fall_c = rx_s_d & ~rx_s;
  assign tick_c = (div_cnt == DIV_W'(DIV - 1));
  // Ticks are counted from START entry: mid start is tick 8, and every later
  // mid-bit point is 16 ticks on, so all sample points share tick_cnt == 7.
  assign sample_c = tick_c && (tick_cnt == 4'd7);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign bad_par_c = ^{shift, par_bit};
`else
  assign bad_par_c = 1'b0;
`endif

  // Receiver state register
  always_ff @(posedge clk_50m) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Receiver next-state and control decode
  always_comb begin
    state_next = state;
    start_c    = 1'b0;
    shift_c    = 1'b0;
    push_c     = 1'b0;
    err_c      = 1'b0;
    case (state)
      IDLE: begin
        if (fall_c) begin
          state_next = START;
          start_c    = 1'b1;
        end
      end
      START: begin
        if (sample_c) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample_c) begin
          shift_c = 1'b1;
          if (bit_cnt == 4'(LAST_BIT)) state_next = STOP;
        end
      end
      STOP: begin
        if (sample_c) begin
          if (!rx_s) begin
            err_c      = 1'b1;
            state_next = WAIT_HIGH;
          end else if (bad_par_c) begin
            err_c      = 1'b1;
            state_next = IDLE;
          end else begin
            push_c     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Oversample divider, tick/bit counters and shift register
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      if (start_c || tick_c) div_cnt <= '0;
      else                   div_cnt <= div_cnt + DIV_W'(1);
      if (start_c) begin
        tick_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        if (tick_c) tick_cnt <= tick_cnt + 4'd1;
        if (shift_c) begin
          bit_cnt <= bit_cnt + 4'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 4'd8) par_bit <= rx_s;
          else                 shift   <= {rx_s, shift[7:1]};
`else
          shift <= {rx_s, shift[7:1]};
`endif
        end
      end
    end
  end

  // A write on a full FIFO is only possible when a read frees a slot this cycle
  assign do_rd_c = rd_en && !empty;
  assign do_wr_c = push_c && (!full || rd_en);

  always_comb begin
    used_next_c = used_words;
    case ({do_wr_c, do_rd_c})
      2'b10:   used_next_c = used_words + CNT_W'(1);
      2'b01:   used_next_c = used_words - CNT_W'(1);
      default: used_next_c = used_words;
    endcase
  end

  // Storage array (no reset needed)
  always_ff @(posedge clk_50m) begin
    if (do_wr_c) mem[wr_ptr] <= shift;
  end

  // FIFO control and registered status outputs
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_out   <= 8'h00;
      used_words <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overrun    <= 1'b0;
      rx_busy    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd_c) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      if (push_c && full && !rd_en) overrun <= 1'b1;
      used_words <= used_next_c;
      empty      <= (used_next_c == '0);
      full       <= (used_next_c == CNT_W'(DEPTH));
      rx_busy    <= (state_next != IDLE);
      frame_err  <= err_c;
    end
  end

endmodule
